// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory bus between the fetch port (p0)
// and the execute-stage memory port (p1) with round-robin grants.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pN_addr/wdata/width   request fields, captured on a strobe
//   pN_rstrobe/wstrobe    one-cycle read / write request
//   pN_rdata              read result, held until the next completion
//   pN_cycle_complete     one-cycle completion pulse
//   pN_err                set with the completion on a watchdog abort
//   mem_*                 shared bus (registered strobes and fields)
//   proto_err             one-cycle pulse when a request is dropped
module dmem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] p0_addr,
    input  logic [63:0] p0_wdata,
    input  logic [1:0]  p0_width,
    input  logic        p0_rstrobe,
    input  logic        p0_wstrobe,
    output logic [63:0] p0_rdata,
    output logic        p0_cycle_complete,
    output logic        p0_err,
    input  logic [63:0] p1_addr,
    input  logic [63:0] p1_wdata,
    input  logic [1:0]  p1_width,
    input  logic        p1_rstrobe,
    input  logic        p1_wstrobe,
    output logic [63:0] p1_rdata,
    output logic        p1_cycle_complete,
    output logic        p1_err,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_dout,
    output logic [1:0]  mem_width,
    output logic        mem_rstrobe,
    output logic        mem_wstrobe,
    input  logic [63:0] mem_din,
    input  logic        mem_cycle_complete,
    output logic        proto_err
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    localparam logic [15:0] TMO   = 16'(TIMEOUT_CYCLES);
    localparam logic        WD_EN = (TIMEOUT_CYCLES != 0);

    logic [1:0]       rs, ws, busy, viol, acc;
    logic [1:0][63:0] in_addr, in_wdata;
    logic [1:0][1:0]  in_width;
    logic             win;

    state_e           state_q, state_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       wr_q, wr_d;
    logic [1:0][63:0] addr_q, addr_d;
    logic [1:0][63:0] wdata_q, wdata_d;
    logic [1:0][1:0]  width_q, width_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [15:0]      wd_q, wd_d;
    logic [63:0]      mem_addr_q, mem_addr_d;
    logic [63:0]      mem_dout_q, mem_dout_d;
    logic [1:0]       mem_width_q, mem_width_d;
    logic             mem_rs_q, mem_rs_d;
    logic             mem_ws_q, mem_ws_d;
    logic [1:0][63:0] rdata_q, rdata_d;
    logic [1:0]       done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic             perr_q, perr_d;

    assign rs       = {p1_rstrobe, p0_rstrobe};
    assign ws       = {p1_wstrobe, p0_wstrobe};
    assign in_addr  = {p1_addr, p0_addr};
    assign in_wdata = {p1_wdata, p0_wdata};
    assign in_width = {p1_width, p0_width};

    // A port stays busy from capture until its completion pulse.
    assign busy[0] = pend_q[0] | (state_q == S_WAIT && !owner_q);
    assign busy[1] = pend_q[1] | (state_q == S_WAIT && owner_q);

    assign viol = (rs | ws) & (busy | (rs & ws));
    assign acc  = (rs ^ ws) & ~busy;

    // On a tie the port that did not win last time goes first.
    assign win = (&pend_q) ? ~last_q : pend_q[1];

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        width_d     = width_q;
        owner_d     = owner_q;
        last_d      = last_q;
        wd_d        = wd_q;
        mem_addr_d  = mem_addr_q;
        mem_dout_d  = mem_dout_q;
        mem_width_d = mem_width_q;
        mem_rs_d    = 1'b0;
        mem_ws_d    = 1'b0;
        rdata_d     = rdata_q;
        done_d      = 2'b00;
        err_d       = 2'b00;
        perr_d      = |viol;

        for (int n = 0; n < 2; n++) begin
            if (acc[n]) begin
                addr_d[n]  = in_addr[n];
                wdata_d[n] = in_wdata[n];
                width_d[n] = in_width[n];
                wr_d[n]    = ws[n];
                pend_d[n]  = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    mem_addr_d  = addr_q[win];
                    mem_dout_d  = wdata_q[win];
                    mem_width_d = width_q[win];
                    mem_rs_d    = ~wr_q[win];
                    mem_ws_d    = wr_q[win];
                    pend_d[win] = 1'b0;
                    owner_d     = win;
                    last_d      = win;
                    wd_d        = 16'd0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_cycle_complete) begin
                    if (!wr_q[owner_q]) begin
                        rdata_d[owner_q] = mem_din;
                    end
                    done_d[owner_q] = 1'b1;
                    state_d         = S_IDLE;
                end else if (WD_EN && wd_q == TMO) begin
                    // The count reached TMO on the last stall edge,
                    // so the bus gets one more cycle to answer.
                    rdata_d[owner_q] = 64'd0;
                    done_d[owner_q]  = 1'b1;
                    err_d[owner_q]   = 1'b1;
                    state_d          = S_IDLE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            wr_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            width_q     <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            wd_q        <= '0;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
            mem_width_q <= '0;
            mem_rs_q    <= 1'b0;
            mem_ws_q    <= 1'b0;
            rdata_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            width_q     <= width_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            wd_q        <= wd_d;
            mem_addr_q  <= mem_addr_d;
            mem_dout_q  <= mem_dout_d;
            mem_width_q <= mem_width_d;
            mem_rs_q    <= mem_rs_d;
            mem_ws_q    <= mem_ws_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            perr_q      <= perr_d;
        end
    end

    assign p0_rdata          = rdata_q[0];
    assign p1_rdata          = rdata_q[1];
    assign p0_cycle_complete = done_q[0];
    assign p1_cycle_complete = done_q[1];
    assign p0_err            = err_q[0];
    assign p1_err            = err_q[1];
    assign mem_addr          = mem_addr_q;
    assign mem_dout          = mem_dout_q;
    assign mem_width         = mem_width_q;
    assign mem_rstrobe       = mem_rs_q;
    assign mem_wstrobe       = mem_ws_q;
    assign proto_err         = perr_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single Raisin64 data-memory bus between two strobe-style requesters. Port 0 is the instruction-fetch path; port 1 is the execute-stage memory unit. Each request is latched on its strobe, granted round-robin, and issued as one bus transaction. The result is returned to the owning port with a one-cycle completion pulse. A programmable watchdog ends hung transactions with an error flag.

## Interface
- TIMEOUT_CYCLES, 256: number of wait cycles before a transaction is forced to finish with an error; 0 disables the watchdog; range 0–65535.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- pN_addr  in  64  request address, sampled on a strobe (N = 0, 1 throughout).
- pN_wdata  in  64  write data, sampled on pN_wstrobe.
- pN_width  in  2  access width code: 0 = 64-bit, 1 = 32-bit, 2 = 16-bit, 3 = 8-bit. Passed through unchanged.
- pN_rstrobe  in  1  one-cycle read request.
- pN_wstrobe  in  1  one-cycle write request.
- pN_rdata  out  64  read data; valid while pN_cycle_complete is high and held until the next completion on that port.
- pN_cycle_complete  out  1  one-cycle completion pulse.
- pN_err  out  1  high with pN_cycle_complete when the transaction timed out.
- mem_addr  out  64  bus address.
- mem_dout  out  64  bus write data.
- mem_width  out  2  bus width code.
- mem_rstrobe  out  1  one-cycle bus read strobe.
- mem_wstrobe  out  1  one-cycle bus write strobe.
- mem_din  in  64  bus read data.
- mem_cycle_complete  in  1  bus completion.
- proto_err  out  1  one-cycle pulse when a request is dropped.

## Operation
- Each port has a holding register: addr, wdata, width, is-write, plus a pend bit.
- A strobe captures the port's inputs and sets pend on the same edge.
- busyN = pendN, or a transaction owned by port N is in flight.
- A strobe is dropped and proto_err pulses on the next cycle when either of these holds at the sampling edge:
  - busyN = 1;
  - rstrobe and wstrobe are both high.
- If both ports violate in the same cycle, there is a single proto_err pulse.
- State machine:
  - IDLE, no pend: stay in IDLE.
  - IDLE, any pend: select the winner, load mem_addr/mem_dout/mem_width from its holding register, assert the matching mem strobe for exactly one cycle, clear the winner's pend, set owner = winner, set last_grant = winner, clear the watchdog, go to WAIT.
  - WAIT, mem_cycle_complete = 1: register mem_din into owner's rdata (reads only; writes leave rdata unchanged), pulse owner's cycle_complete, go to IDLE.
  - WAIT, watchdog expiry: pulse owner's cycle_complete and err, force owner's rdata to 0, go to IDLE.
- Winner selection:
  - Only one pend set: that port wins.
  - Both pends set: the port not equal to last_grant wins.
- Watchdog:
  - 16-bit counter, incremented on every WAIT cycle without mem_cycle_complete.
  - Expiry is at the TIMEOUT_CYCLES-th such cycle.
  - mem_cycle_complete in the expiry cycle wins over the error.
- mem_cycle_complete outside WAIT is ignored.
- mem_rstrobe and mem_wstrobe are never high together, and never high outside the issue cycle.

## Timing
- Reset: every output is 0, all pend bits are 0, state = IDLE, last_grant = 1 (so port 0 wins the first tie), watchdog = 0.
- Reset wins over every other event, including mid-WAIT. A mem_cycle_complete arriving after reset produces no port pulse.
- Latency: strobe in cycle c → pend set in c+1 → mem strobe in c+2.
- mem_cycle_complete may arrive as early as the mem strobe cycle. If it arrives in cycle w, the port completes in w+1.
- Back-to-back: state is IDLE in w+1. If another pend exists, the next mem strobe is in w+2.
- A port may re-strobe in its completion cycle (w+1). Its busy bit is already clear, so the request is accepted.
- Minimum spacing between mem strobes is 2 cycles.

## Test plan
- Read, port 1: after reset, p1_rstrobe with addr 0x1000 and width 0 at cycle 5. Expect mem_rstrobe and mem_addr = 0x1000 at cycle 7. The model asserts complete at cycle 10 with mem_din = 0xDEADBEEFCAFEF00D. Expect p1_cycle_complete and that p1_rdata value at cycle 11, with p1_err = 0.
- Write, port 0: p0_wstrobe with addr 0x20, wdata 0x55, width 3. Expect a single mem_wstrobe with mem_dout = 0x55 and mem_width = 3, followed by p0_cycle_complete with p0_rdata unchanged.
- Fairness: both ports strobe in the same cycle after reset. Port 0 is granted first. Both ports then re-strobe in each of their completion cycles for 8 transactions. Expect grants to alternate 0,1,0,1,… and mem strobe spacing ≥ 2 cycles.
- Timeout: TIMEOUT_CYCLES = 8 and the model never completes. Expect p0_cycle_complete, p0_err = 1 and p0_rdata = 0 exactly 9 cycles after mem_rstrobe. A complete arriving later produces no pulse.
- Protocol errors: p1_rstrobe while p1 is pending → one proto_err pulse and only one bus transaction. Simultaneous p0_rstrobe and p0_wstrobe → proto_err pulse and no bus activity.
- Reset during WAIT: assert rst_n = 0 mid-transaction. Expect all outputs 0 on the next cycle and pend cleared. A late mem_cycle_complete produces no port pulse, and the next tie is granted to port 0.
